chunked_addsub_sequencer: RTL and testbench



---
 rtl/chunked_addsub_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_chunked_addsub_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub_sequencer.sv
// Wide add/subtract built from one N-bit ripple adder and subtractor, time-shared over K chunks.
// Optional ones'-complement end-around-carry pass: define ONES_COMPLEMENT_EN.

module ripple_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  always_comb begin
    c[0] = ci;
    s    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[N];
  end
endmodule

module ripple_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic [N-1:0] d,
  output logic         bo
);
  logic [N:0] br;

  always_comb begin
    br[0] = bi;
    d     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      d[i]    = a[i] ^ b[i] ^ br[i];
      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bo = br[N];
  end
endmodule

module chunked_addsub_sequencer #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
`ifdef ONES_COMPLEMENT_EN
  input  logic                 op_ones,
`endif
  input  logic [N*K-1:0]       a,
  input  logic [N*K-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*K-1:0]       result,
  output logic                 carry_out,
  output logic                 overflow
);
  localparam int unsigned W     = N * K;
  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef ONES_COMPLEMENT_EN
    S_EAC,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
`ifdef ONES_COMPLEMENT_EN
  logic               ones_q, ones_d;
`endif

  logic [N-1:0]       x_c, y_c, sum_c, diff_c, chunk_res_c;
  logic               add_co_c, sub_bo_c, chunk_co_c, last_c;

  // Select the current chunk's operands; the EAC pass folds the end-around bit into result.
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_c = a_q[i*N +: N];
        y_c = b_q[i*N +: N];
`ifdef ONES_COMPLEMENT_EN
        if (state_q == S_EAC) begin
          x_c = result_q[i*N +: N];
          y_c = '0;
        end
`endif
      end
    end
  end

  ripple_adder #(.N(N)) u_add (
    .a(x_c), .b(y_c), .ci(carry_q), .s(sum_c), .co(add_co_c)
  );

  ripple_subtractor #(.N(N)) u_sub (
    .a(x_c), .b(y_c), .bi(carry_q), .d(diff_c), .bo(sub_bo_c)
  );

  assign chunk_res_c = sub_q ? diff_c : sum_c;
  assign chunk_co_c  = sub_q ? sub_bo_c : add_co_c;
  assign last_c      = (idx_q == IDX_W'(K - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
`ifdef ONES_COMPLEMENT_EN
    ones_d      = ones_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
`ifdef ONES_COMPLEMENT_EN
          ones_d  = op_ones;
`endif
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN
`ifdef ONES_COMPLEMENT_EN
      , S_EAC
`endif
      : begin
        for (int unsigned i = 0; i < K; i++) begin
          if (idx_q == IDX_W'(i)) result_d[i*N +: N] = chunk_res_c;
        end
        carry_d = chunk_co_c;
        idx_d   = idx_q + IDX_W'(1);
        if (last_c) begin
          idx_d   = '0;
          state_d = S_DONE;
          // Add: same-sign operands, result sign flips. Sub: operand signs differ, result leaves a's sign.
          overflow_d = (a_q[W-1] ^ result_d[W-1]) & ~(a_q[W-1] ^ b_q[W-1] ^ sub_q);
          if (state_q == S_RUN) carry_out_d = chunk_co_c;
`ifdef ONES_COMPLEMENT_EN
          if (state_q == S_RUN && ones_q && chunk_co_c) begin
            state_d = S_EAC;
            carry_d = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ONES_COMPLEMENT_EN
      ones_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ONES_COMPLEMENT_EN
      ones_q      <= ones_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_addsub_sequencer.sv
// Scoreboard bench for chunked_addsub_sequencer (N=4, K=2); honours ONES_COMPLEMENT_EN if defined.

module tb_chunked_addsub_sequencer;
  localparam int unsigned N = 4;
  localparam int unsigned K = 2;
  localparam int unsigned W = N * K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
`ifdef ONES_COMPLEMENT_EN
  logic         op_ones = 1'b0;
`endif
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  chunked_addsub_sequencer #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub),
`ifdef ONES_COMPLEMENT_EN
    .op_ones(op_ones),
`endif
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           acc_e;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   hold_rdy = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide arithmetic, optional end-around carry/borrow, sign rule on the final value.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sub, input logic ones);
    exp_t   e;
    longint m  = longint'(1) << W;
    longint s;
    logic   c;
    logic [W-1:0] r;
    if (!sub) begin
      s = longint'(av) + longint'(bv);
      c = (s >= m);
      s = s % m;
      if (ones && c) s = (s + 1) % m;
    end else begin
      c = (av < bv);
      s = (longint'(av) - longint'(bv) + m) % m;
      if (ones && c) s = (s + m - 1) % m;
    end
    r = W'(s);
    e.res = r;
    e.co  = c;
    if (!sub) e.ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    else      e.ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    e.lat   = (ones && c) ? int'(2 * K) : int'(K);
    e.acc_e = 0;
    return e;
  endfunction

  // Consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor: compares held outputs every cycle out_valid is up; pops on handshake.
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        if (!prev_ov) chk("latency", 32'(cyc - sbq[0].acc_e), 32'(sbq[0].lat));
        chk("result", 32'(result), 32'(sbq[0].res));
        chk("carry_out", 32'(carry_out), 32'(sbq[0].co));
        chk("overflow", 32'(overflow), 32'(sbq[0].ov));
        if (out_ready) void'(sbq.pop_front());
      end
    end
    prev_ov = rst_n && out_valid && !out_ready;
  end

  // Called at posedge+1; holds in_valid until accepted, then records expectation.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sub, input logic ones, output int acc);
    exp_t e;
    bit   done = 1'b0;
    a = av; b = bv; op_sub = sub;
`ifdef ONES_COMPLEMENT_EN
    op_ones = ones;
`endif
    in_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(av, bv, sub, ones);
        e.acc_e = cyc + 1;
        acc = e.acc_e;
        sbq.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("issue_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sbq.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sbq.size()), 32'(0));
  endtask

  initial begin
    int e1, e2;
    logic ones_r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_carry_out", 32'(carry_out), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'h7F, 8'h01, 1'b0, 1'b0, e1);
    issue(8'h00, 8'h01, 1'b1, 1'b0, e1);
    issue(8'h80, 8'h01, 1'b1, 1'b0, e1);
    drain();

    // Stalled consumer: outputs held, in_ready low, extra in_valid ignored.
    hold_rdy = 1'b1;
    issue(8'hFF, 8'h01, 1'b0, 1'b0, e1);
    repeat (K + 2) begin @(posedge clk); #1; end
    chk("stall_in_ready", 32'(in_ready), 32'(0));
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    hold_rdy = 1'b0;
    drain();

    // Back-to-back spacing with out_ready held high.
    issue(8'h12, 8'h34, 1'b0, 1'b0, e1);
    issue(8'h50, 8'h60, 1'b1, 1'b0, e2);
    chk("b2b_spacing", 32'(e2 - e1), 32'(K + 2));
    drain();

    // Reset during chunk 1 aborts silently.
    a = 8'h3C; b = 8'h5A; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    rst_n = 1'b1;
    repeat (2 * K + 4) begin @(posedge clk); #1; end

`ifdef ONES_COMPLEMENT_EN
    issue(8'hFE, 8'h05, 1'b0, 1'b1, e1);
    issue(8'h05, 8'h09, 1'b1, 1'b1, e1);
    issue(8'h10, 8'h20, 1'b0, 1'b1, e1);
    drain();
`endif

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ones_r = 1'b0;
`ifdef ONES_COMPLEMENT_EN
      ones_r = 1'($urandom_range(0, 1));
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ones_r, e1);
    end
    drain();
    rand_rdy = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
